lsu_axil_master: RTL and testbench

AXI4-Lite initiator that turns single load/store requests from the LSU pipeline stage into AXI4-Lite read or write transactions toward the crossbar. It reaches the CLINT, UART and SRAM slaves. It holds exactly one transaction outstanding, registers every AXI output, and returns read data or write completion through a valid/ready response port.

---
 rtl/lsu_axil_master_if.sv | 35 +++
 rtl/lsu_axil_master.sv | 179 +++++++++++++++++
 tb/tb_lsu_axil_master.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_axil_master_if.sv
// AXI4-Lite channel bundle between the LSU initiator (master) and the crossbar (slave).
interface lsu_axil_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/lsu_axil_master.sv
// Single-outstanding AXI4-Lite initiator for LSU loads/stores; all bus and response outputs registered.
// Optional LSU_ALIGN_CHECK_EN rejects misaligned requests locally without touching the bus.
module lsu_axil_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  lsu_axil_master_if.master       axi
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4,
    RESP    = 3'd5
  } state_t;

  state_t state_r;
  logic   aw_done_r;
  logic   w_done_r;
  logic   accept_s;
  logic   aw_now_s;
  logic   w_now_s;
  logic   bad_align_s;

  // SLVERR and DECERR both report as a bus error.
  function automatic logic resp_is_error(input logic [1:0] resp);
    return (resp == 2'b10) || (resp == 2'b11);
  endfunction

`ifdef LSU_ALIGN_CHECK_EN
  // Byte stores may land anywhere; halfword stores need an even address.
  function automatic logic misaligned(input logic we, input logic [1:0] lsb,
                                      input logic [STRB_WIDTH-1:0] strb);
    logic result;
    if (lsb == 2'b00) begin
      result = 1'b0;
    end else if (!we) begin
      result = 1'b1;
    end else if ($onehot(strb)) begin
      result = 1'b0;
    end else if (!lsb[0] && ((strb == STRB_WIDTH'(4'b0011)) || (strb == STRB_WIDTH'(4'b1100)))) begin
      result = 1'b0;
    end else begin
      result = 1'b1;
    end
    return result;
  endfunction

  assign bad_align_s = misaligned(req_we, req_addr[1:0], req_wstrb);
`else
  assign bad_align_s = 1'b0;
`endif

  assign req_ready = resetn && (state_r == IDLE);
  assign accept_s  = req_valid && req_ready;
  assign aw_now_s  = aw_done_r || (axi.awvalid && axi.awready);
  assign w_now_s   = w_done_r  || (axi.wvalid  && axi.wready);

  // Transaction FSM with registered bus and response outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r     <= IDLE;
      aw_done_r   <= 1'b0;
      w_done_r    <= 1'b0;
      axi.araddr  <= '0;
      axi.arvalid <= 1'b0;
      axi.rready  <= 1'b0;
      axi.awaddr  <= '0;
      axi.awvalid <= 1'b0;
      axi.wdata   <= '0;
      axi.wstrb   <= '0;
      axi.wvalid  <= 1'b0;
      axi.bready  <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            if (bad_align_s) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
              state_r   <= RESP;
            end else if (req_we) begin
              axi.awaddr  <= req_addr;
              axi.wdata   <= req_wdata;
              axi.wstrb   <= req_wstrb;
              axi.awvalid <= 1'b1;
              axi.wvalid  <= 1'b1;
              aw_done_r   <= 1'b0;
              w_done_r    <= 1'b0;
              state_r     <= WR_REQ;
            end else begin
              axi.araddr  <= req_addr;
              axi.arvalid <= 1'b1;
              state_r     <= RD_ADDR;
            end
          end
        end
        RD_ADDR: begin
          if (axi.arready) begin
            axi.arvalid <= 1'b0;
            axi.rready  <= 1'b1;
            state_r     <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (axi.rvalid) begin
            axi.rready <= 1'b0;
            rsp_rdata  <= axi.rdata;
            rsp_err    <= resp_is_error(axi.rresp);
            rsp_valid  <= 1'b1;
            state_r    <= RESP;
          end
        end
        WR_REQ: begin
          // AW and W retire independently; the done flags remember which already went.
          if (axi.awready) begin
            axi.awvalid <= 1'b0;
          end
          if (axi.wready) begin
            axi.wvalid <= 1'b0;
          end
          aw_done_r <= aw_now_s;
          w_done_r  <= w_now_s;
          if (aw_now_s && w_now_s) begin
            axi.bready <= 1'b1;
            aw_done_r  <= 1'b0;
            w_done_r   <= 1'b0;
            state_r    <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (axi.bvalid) begin
            axi.bready <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= resp_is_error(axi.bresp);
            rsp_valid  <= 1'b1;
            state_r    <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_r   <= IDLE;
          end
        end
        default: begin
          axi.arvalid <= 1'b0;
          axi.rready  <= 1'b0;
          axi.awvalid <= 1'b0;
          axi.wvalid  <= 1'b0;
          axi.bready  <= 1'b0;
          rsp_valid   <= 1'b0;
          aw_done_r   <= 1'b0;
          w_done_r    <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_axil_master.sv
// Self-checking bench for lsu_axil_master: vector table, cycle-driven AXI slave model, response scoreboard.
module tb_lsu_axil_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          resetn;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [SW-1:0] req_wstrb;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lsu_axil_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

  lsu_axil_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .axi       (axi)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          ar_dly;
    int          aw_dly;
    int          w_dly;
    int          rb_dly;
    int          hold;
    int          lat;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        no_axi;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wstrb, input logic [31:0] rdata, input logic [1:0] resp,
                              input int ar_dly, input int aw_dly, input int w_dly, input int rb_dly,
                              input int hold, input int lat, input logic [31:0] exp_rdata,
                              input logic exp_err, input logic no_axi);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb; v.rdata = rdata; v.resp = resp;
    v.ar_dly = ar_dly; v.aw_dly = aw_dly; v.w_dly = w_dly; v.rb_dly = rb_dly;
    v.hold = hold; v.lat = lat; v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.no_axi = no_axi;
    return v;
  endfunction

  task automatic idle_slave();
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = 32'h0; axi.rresp = 2'b00;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
  endtask

  // One transaction; each iteration observes the cycle and sets inputs for the coming edge.
  task automatic run_vec(input vec_t v);
    int   acc_t = 0, ar_c = 0, aw_c = 0, w_c = 0, rb_c = 0, hold_c = 0;
    bit   acc = 1'b0, ar_hs = 1'b0, aw_hs = 1'b0, w_hs = 1'b0, r_done = 1'b0, b_done = 1'b0;
    bit   seen_rsp = 1'b0, done = 1'b0;
    exp_t e;
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata; req_wstrb = v.wstrb;
    for (int t = 0; t < 80 && !done; t++) begin
      if (acc) begin
        req_valid = 1'b0;
      end else if (req_valid && req_ready) begin
        acc = 1'b1; acc_t = t;
        e.rdata = v.exp_rdata; e.err = v.exp_err;
        sb.push_back(e);
      end
      if (v.no_axi) chk("no_axi_valid", {31'b0, axi.arvalid | axi.awvalid | axi.wvalid}, 32'h0);
      // R and B answer only handshakes completed at earlier edges
      if (ar_hs && !r_done) begin
        axi.rvalid = (rb_c >= v.rb_dly); rb_c++;
        axi.rdata = v.rdata; axi.rresp = v.resp;
        if (axi.rvalid && axi.rready) r_done = 1'b1;
      end else begin
        axi.rvalid = 1'b0;
      end
      if (axi.rready) chk("rready_after_ar", {31'b0, ar_hs}, 32'h1);
      if (aw_hs && w_hs && !b_done) begin
        axi.bvalid = (rb_c >= v.rb_dly); rb_c++;
        axi.bresp = v.resp;
        if (axi.bvalid && axi.bready) b_done = 1'b1;
      end else begin
        axi.bvalid = 1'b0;
      end
      if (axi.bready) chk("bready_after_aw_w", {31'b0, aw_hs && w_hs}, 32'h1);
      if (axi.arvalid) begin
        chk("araddr", axi.araddr, v.addr);
        chk("arvalid_once", {31'b0, ar_hs}, 32'h0);
        axi.arready = (ar_c >= v.ar_dly); ar_c++;
        if (axi.arready) ar_hs = 1'b1;
      end else begin
        axi.arready = 1'b0;
      end
      if (axi.awvalid) begin
        chk("awaddr", axi.awaddr, v.addr);
        chk("awvalid_once", {31'b0, aw_hs}, 32'h0);
        axi.awready = (aw_c >= v.aw_dly); aw_c++;
        if (axi.awready) aw_hs = 1'b1;
      end else begin
        axi.awready = 1'b0;
      end
      if (axi.wvalid) begin
        chk("wdata", axi.wdata, v.wdata);
        chk("wstrb", {28'b0, axi.wstrb}, {28'b0, v.wstrb});
        chk("wvalid_once", {31'b0, w_hs}, 32'h0);
        axi.wready = (w_c >= v.w_dly); w_c++;
        if (axi.wready) w_hs = 1'b1;
      end else begin
        axi.wready = 1'b0;
      end
      if (rsp_valid) begin
        if (!seen_rsp) begin
          seen_rsp = 1'b1;
          chk("rsp_latency", 32'(t - acc_t), 32'(v.lat));
        end
        chk("req_ready_busy", {31'b0, req_ready}, 32'h0);
        if (sb.size() == 0) begin
          chk("rsp_without_request", {31'b0, rsp_valid}, 32'h0);
        end else begin
          chk("rsp_rdata", rsp_rdata, sb[0].rdata);
          chk("rsp_err", {31'b0, rsp_err}, {31'b0, sb[0].err});
        end
        rsp_ready = (hold_c >= v.hold); hold_c++;
        if (rsp_ready) begin
          if (sb.size() != 0) void'(sb.pop_front());
          done = 1'b1;
        end
      end else begin
        rsp_ready = 1'b0;
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b0; req_valid = 1'b0;
    idle_slave();
    if (!done) chk("txn_timeout", 32'h0, 32'h1);
    chk("req_ready_after_rsp", {31'b0, req_ready}, 32'h1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_arvalid"}, {31'b0, axi.arvalid}, 32'h0);
    chk({tag, "_rready"},  {31'b0, axi.rready},  32'h0);
    chk({tag, "_awvalid"}, {31'b0, axi.awvalid}, 32'h0);
    chk({tag, "_wvalid"},  {31'b0, axi.wvalid},  32'h0);
    chk({tag, "_bready"},  {31'b0, axi.bready},  32'h0);
    chk({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'h0);
    chk({tag, "_req_ready"}, {31'b0, req_ready}, 32'h0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    chk({tag, "_rsp_err"},   {31'b0, rsp_err}, 32'h0);
    chk({tag, "_araddr"},    axi.araddr, 32'h0);
    chk({tag, "_awaddr"},    axi.awaddr, 32'h0);
  endtask

  initial begin
    resetn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
    req_wdata = 32'h0; req_wstrb = 4'h0; rsp_ready = 1'b0;
    idle_slave();

    vecs[0] = mk(1'b0, 32'h0200_BFF8, 32'h0, 4'h0, 32'h0000_1234, 2'b00, 0, 0, 0, 0, 0, 3, 32'h0000_1234, 1'b0, 1'b0);
    vecs[1] = mk(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 2'b00, 0, 2, 0, 0, 0, 5, 32'h0, 1'b0, 1'b0);
    vecs[2] = mk(1'b0, 32'h8000_0020, 32'h0, 4'h0, 32'hCAFE_0000, 2'b10, 0, 0, 0, 0, 5, 3, 32'hCAFE_0000, 1'b1, 1'b0);
    vecs[3] = mk(1'b1, 32'h1000_0004, 32'h0000_00AB, 4'h1, 32'h0, 2'b11, 0, 0, 3, 2, 0, 8, 32'h0, 1'b1, 1'b0);
    vecs[4] = mk(1'b1, 32'h2000_0008, 32'h1234_5678, 4'hC, 32'h0, 2'b00, 0, 1, 1, 0, 0, 4, 32'h0, 1'b0, 1'b0);
`ifdef LSU_ALIGN_CHECK_EN
    vecs[5] = mk(1'b0, 32'h8000_0002, 32'h0, 4'h0, 32'h5555_AAAA, 2'b01, 2, 0, 0, 3, 0, 1, 32'h0, 1'b1, 1'b1);
`else
    vecs[5] = mk(1'b0, 32'h8000_0002, 32'h0, 4'h0, 32'h5555_AAAA, 2'b01, 2, 0, 0, 3, 0, 8, 32'h5555_AAAA, 1'b0, 1'b0);
`endif
    vecs[6] = mk(1'b1, 32'h8000_0003, 32'hEF00_0000, 4'h8, 32'h0, 2'b00, 0, 0, 0, 0, 0, 3, 32'h0, 1'b0, 1'b0);
    vecs[7] = mk(1'b0, 32'h0000_0100, 32'h0, 4'h0, 32'hFFFF_FFFF, 2'b11, 0, 0, 0, 0, 2, 3, 32'hFFFF_FFFF, 1'b1, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("req_ready_out_of_reset", {31'b0, req_ready}, 32'h1);

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i]);
    end

    // Reset while waiting for read data.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0300_0000;
    @(posedge clk); #1;
    req_valid = 1'b0; axi.arready = 1'b1;
    @(posedge clk); #1;
    axi.arready = 1'b0;
    chk("rready_before_reset", {31'b0, axi.rready}, 32'h1);
    resetn = 1'b0;
    @(posedge clk); #1;
    chk_reset_outputs("midreset");
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("req_ready_after_midreset", {31'b0, req_ready}, 32'h1);
    chk("rsp_valid_after_midreset", {31'b0, rsp_valid}, 32'h0);

    run_vec(vecs[0]);
    run_vec(vecs[1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
